level_cdc_sync: RTL and testbench

Level synchronizer that carries a slow-changing control level from the source clock domain (clk_s) into an unrelated destination domain (clk_d). The source level is registered in clk_s, then passed through a multi-flop synchronizer in clk_d. The destination reset is derived locally from rstn_s by a reset synchronizer. The block sits at every clock-domain boundary where a quasi-static enable or mode bit crosses, and is built from two sub-blocks: rstn_sync (reset synchronizer) and sync_cell (flop-chain synchronizer).

---
 rtl/level_cdc_sync_if.sv | 9 +
 rtl/level_cdc_sync.sv | 55 +++++
 tb/tb_level_cdc_sync.sv | 119 +++++++++++
 3 files changed

// File: rtl/level_cdc_sync_if.sv
// level_cdc_sync_if: control level launched in clk_s and its synchronized copy in clk_d
interface level_cdc_sync_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] ctrl_s;
    logic [WIDTH-1:0] ctrl_d;
    modport master (output ctrl_s, input ctrl_d);
    modport slave (input ctrl_s, output ctrl_d);
endinterface

// File: rtl/level_cdc_sync.sv
// level_cdc_sync: registers a quasi-static level in clk_s and synchronizes it into clk_d
// with a locally synchronized clk_d reset derived from rstn_s.
module rstn_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn_in,
    output logic rstn_out
);
    logic [STAGES-1:0] chain;
    always_ff @(posedge clk or negedge rstn_in)
        if (!rstn_in) chain <= '0;
        else          chain <= {chain[STAGES-2:0], 1'b1};
    assign rstn_out = chain[STAGES-1];
endmodule

module sync_cell #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [STAGES-1:0][WIDTH-1:0] chain;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) chain <= '0;
        else       chain <= {chain[STAGES-2:0], d};
    assign q = chain[STAGES-1];
endmodule

module level_cdc_sync #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int RST_STAGES  = 2
) (
    input  logic clk_s,
    input  logic rstn_s,
    input  logic clk_d,
    level_cdc_sync_if.slave bus
);
    logic [WIDTH-1:0] ctrl_s_q;
    logic             rstn_d;
    // only a flop may drive the crossing, never combinational logic
    always_ff @(posedge clk_s or negedge rstn_s)
        if (!rstn_s) ctrl_s_q <= '0;
        else         ctrl_s_q <= bus.ctrl_s;
    rstn_sync #(.STAGES(RST_STAGES)) u_rst (
        .clk(clk_d), .rstn_in(rstn_s), .rstn_out(rstn_d)
    );
    sync_cell #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
        .clk(clk_d), .rstn(rstn_d), .d(ctrl_s_q), .q(bus.ctrl_d)
    );
endmodule

// File: tb/tb_level_cdc_sync.sv
// tb_level_cdc_sync: directed checks of reset behaviour, latency and level passing
// for a 1-bit and a 4-bit instance sharing clocks and reset.
module tb_level_cdc_sync;
    logic clk_s = 1'b0;
    logic clk_d = 1'b0;
    logic rstn_s;
    int   checks = 0;
    int   errors = 0;
    int   hi;
    int   n;

    level_cdc_sync_if #(.WIDTH(1)) b1 ();
    level_cdc_sync_if #(.WIDTH(4)) b4 ();

    level_cdc_sync #(.WIDTH(1)) dut1 (.clk_s(clk_s), .rstn_s(rstn_s), .clk_d(clk_d), .bus(b1));
    level_cdc_sync #(.WIDTH(4)) dut4 (.clk_s(clk_s), .rstn_s(rstn_s), .clk_d(clk_d), .bus(b4));

    always #5 clk_s = ~clk_s;
    initial begin
        #3;
        forever #10 clk_d = ~clk_d;
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v1, input logic [3:0] v4, input string tag);
        @(negedge clk_s);
        b1.ctrl_s = v1;
        b4.ctrl_s = v4;
        @(posedge clk_s);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_d);
            #1;
            n++;
            if (b1.ctrl_d === v1 && b4.ctrl_d === v4) break;
        end
        chk({tag, "_d1"}, {3'b0, b1.ctrl_d}, {3'b0, v1});
        chk({tag, "_d4"}, b4.ctrl_d, v4);
        chk({tag, "_lat"}, n[3:0], 4'd2);
        repeat (3) @(posedge clk_d);
        #1;
        chk({tag, "_hold1"}, {3'b0, b1.ctrl_d}, {3'b0, v1});
        chk({tag, "_hold4"}, b4.ctrl_d, v4);
    endtask

    initial begin
        rstn_s = 1'b0;
        b1.ctrl_s = 1'b1;
        b4.ctrl_s = 4'hF;
        #1;
        chk("rst_async_d1", {3'b0, b1.ctrl_d}, 4'h0);
        chk("rst_async_d4", b4.ctrl_d, 4'h0);
        repeat (3) @(posedge clk_d);
        #1;
        chk("rst_hold_d1", {3'b0, b1.ctrl_d}, 4'h0);
        chk("rst_hold_d4", b4.ctrl_d, 4'h0);
        chk("rst_hold_rstn_d", {3'b0, dut1.rstn_d}, 4'h0);
        @(posedge clk_s);
        #1 rstn_s = 1'b1;
        @(posedge clk_d);
        #1;
        chk("rel_e1_rstn_d", {3'b0, dut1.rstn_d}, 4'h0);
        chk("rel_e1_d1", {3'b0, b1.ctrl_d}, 4'h0);
        @(posedge clk_d);
        #1;
        chk("rel_e2_rstn_d", {3'b0, dut1.rstn_d}, 4'h1);
        chk("rel_e2_d1", {3'b0, b1.ctrl_d}, 4'h0);
        chk("rel_e2_d4", b4.ctrl_d, 4'h0);
        @(posedge clk_d);
        #1;
        chk("rel_e3_d1", {3'b0, b1.ctrl_d}, 4'h0);
        chk("rel_e3_d4", b4.ctrl_d, 4'h0);
        @(posedge clk_d);
        #1;
        chk("rel_e4_d1", {3'b0, b1.ctrl_d}, 4'h1);
        chk("rel_e4_d4", b4.ctrl_d, 4'hF);
        step(1'b0, 4'hA, "fall_A");
        step(1'b1, 4'h5, "rise_5");
        step(1'b0, 4'h0, "fall_0");
        @(negedge clk_s);
        b1.ctrl_s = 1'b1;
        @(negedge clk_s);
        @(negedge clk_s);
        b1.ctrl_s = 1'b0;
        hi = 0;
        repeat (6) begin
            @(posedge clk_d);
            #1;
            if (b1.ctrl_d === 1'b1) hi++;
        end
        chk("short_width", {3'b0, (hi >= 1 && hi <= 2)}, 4'h1);
        chk("short_end", {3'b0, b1.ctrl_d}, 4'h0);
        step(1'b1, 4'hA, "pre_rst");
        @(negedge clk_s);
        rstn_s = 1'b0;
        #1;
        chk("mid_rst_d1", {3'b0, b1.ctrl_d}, 4'h0);
        chk("mid_rst_d4", b4.ctrl_d, 4'h0);
        @(negedge clk_s);
        chk("mid_rst_hold_d1", {3'b0, b1.ctrl_d}, 4'h0);
        rstn_s = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk_d);
            #1;
            chk($sformatf("mid_rel_e%0d_d1", i), {3'b0, b1.ctrl_d}, {3'b0, i == 4});
            chk($sformatf("mid_rel_e%0d_d4", i), b4.ctrl_d, (i == 4) ? 4'hA : 4'h0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
